// File: rtl/mem_stage_pkg.sv
// Shared types and lane helpers for the memory-access stage.
// The package keeps the codebase name `definitions`.
package definitions;

    typedef logic [4:0] RegAddr;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } MemSize;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } MemState;

    function automatic logic is_misaligned(input MemSize sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'd0);
            default: mis = (off != 2'd0);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enables(input MemSize sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate_store(input MemSize sz, input logic [31:0] sd);
        logic [31:0] wd;
        case (sz)
            SZ_BYTE: wd = {4{sd[7:0]}};
            SZ_HALF: wd = {2{sd[15:0]}};
            SZ_WORD: wd = sd;
            default: wd = sd;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load extraction: selects the addressed byte/half from a read word and
// sign- or zero-extends it to 32 bits.
module load_align
    import definitions::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  MemSize      mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] result
);

    logic [31:0] byte_lane_s;
    logic [31:0] half_lane_s;

    assign byte_lane_s = rdata >> {addr, 3'b000};
    assign half_lane_s = rdata >> {addr[1], 4'b0000};

    // Lane select and extension
    always_comb begin
        result = rdata;
        case (mem_size)
            SZ_BYTE: result = {{24{~mem_unsigned & byte_lane_s[7]}}, byte_lane_s[7:0]};
            SZ_HALF: result = {{16{~mem_unsigned & half_lane_s[15]}}, half_lane_s[15:0]};
            SZ_WORD: result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues a registered request/ready data-memory
// transaction for loads/stores and stalls upstream until it completes.
module mem_stage
    import definitions::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  MemSize      mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic        reg_write,
    input  logic        memToReg,
    input  RegAddr      rd_a,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        misalign_err,
    output logic        reg_write_o,
    output logic        memToReg_o,
    output logic [31:0] mem_out_o,
    output logic [31:0] alu_out_o,
    output RegAddr      rd_a_o
);

    MemState     state_r;
    MemState     state_nxt_s;
    logic        dmem_req_r;
    logic        dmem_we_r;
    logic [31:0] dmem_addr_r;
    logic [3:0]  dmem_be_r;
    logic [31:0] dmem_wdata_r;
    logic [31:0] rdata_q_r;
    logic [31:0] load_s;
    logic        mem_op_s;
    logic        misalign_s;
    logic        start_s;

    assign mem_op_s   = valid & (mem_read | mem_write);
    assign misalign_s = mem_op_s & is_misaligned(mem_size, alu_out[1:0]);
    assign start_s    = mem_op_s & ~misalign_s;

    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_be    = dmem_be_r;
    assign dmem_wdata = dmem_wdata_r;
    assign alu_out_o  = alu_out;
    assign rd_a_o     = rd_a;
    assign memToReg_o = memToReg;

    // Upstream holds size and address bits through DONE, so the live inputs
    // steer extraction of the captured word.
    load_align u_load_align (
        .rdata        (rdata_q_r),
        .addr         (alu_out[1:0]),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .result       (load_s)
    );

    // State register, request fields and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'd0;
            dmem_be_r    <= 4'd0;
            dmem_wdata_r <= 32'd0;
            rdata_q_r    <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        dmem_req_r   <= 1'b1;
                        dmem_we_r    <= mem_write;
                        dmem_addr_r  <= {alu_out[31:2], 2'b00};
                        dmem_be_r    <= byte_enables(mem_size, alu_out[1:0]);
                        dmem_wdata_r <= replicate_store(mem_size, store_data);
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        dmem_req_r <= 1'b0;
                        rdata_q_r  <= dmem_rdata;
                    end
                end
                default: dmem_req_r <= 1'b0;
            endcase
        end
    end

    // Next state and handshake outputs; reset forces the idle pass-through view
    always_comb begin
        state_nxt_s  = state_r;
        stall        = 1'b0;
        misalign_err = 1'b0;
        reg_write_o  = 1'b0;
        mem_out_o    = 32'd0;
        if (rst) begin
            state_nxt_s = IDLE;
            reg_write_o = valid & reg_write & ~mem_op_s;
        end else begin
            case (state_r)
                IDLE: begin
                    reg_write_o  = valid & reg_write & ~mem_op_s;
                    misalign_err = misalign_s;
                    stall        = start_s;
                    state_nxt_s  = start_s ? BUSY : IDLE;
                end
                BUSY: begin
                    stall       = 1'b1;
                    state_nxt_s = dmem_ready ? DONE : BUSY;
                end
                DONE: begin
                    reg_write_o = reg_write & ~mem_write;
                    mem_out_o   = load_s;
                    state_nxt_s = IDLE;
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops
// against an arithmetic reference model and a bench-side memory responder.
module tb_mem_stage;
    import definitions::*;

    logic        clk = 1'b0;
    logic        rst, valid, mem_read, mem_write, mem_unsigned;
    MemSize      mem_size;
    logic [31:0] alu_out, store_data;
    logic        reg_write, memToReg;
    RegAddr      rd_a;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall, misalign_err, reg_write_o, memToReg_o;
    logic [31:0] mem_out_o, alu_out_o;
    RegAddr      rd_a_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .alu_out(alu_out),
        .store_data(store_data), .reg_write(reg_write), .memToReg(memToReg), .rd_a(rd_a),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .misalign_err(misalign_err), .reg_write_o(reg_write_o),
        .memToReg_o(memToReg_o), .mem_out_o(mem_out_o), .alu_out_o(alu_out_o), .rd_a_o(rd_a_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, written from the lane rules with plain arithmetic
    function automatic bit m_misaligned(input MemSize sz, input logic [31:0] a);
        if (sz == SZ_HALF) return (a % 2) != 0;
        if (sz == SZ_WORD) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_be(input MemSize sz, input logic [31:0] a);
        if (sz == SZ_BYTE) return 32'd1 << (a % 4);
        if (sz == SZ_HALF) return ((a % 4) >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input MemSize sz, input logic [31:0] sd);
        if (sz == SZ_BYTE) return (sd % 32'd256) * 32'h01010101;
        if (sz == SZ_HALF) return (sd % 32'd65536) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input MemSize sz, input bit uns);
        logic [31:0] v;
        if (sz == SZ_BYTE) begin
            v = (w >> (8 * (a % 4))) % 32'd256;
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
            return v;
        end
        if (sz == SZ_HALF) begin
            v = (w >> (16 * ((a % 4) / 2))) % 32'd65536;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
            return v;
        end
        return w;
    endfunction

    // One instruction through the stage, with the bench acting as data memory
    task automatic run_op(input bit v, input bit rd, input bit wr, input MemSize sz,
                          input bit uns, input logic [31:0] addr, input logic [31:0] sd,
                          input bit rw, input bit mtr, input logic [4:0] rda,
                          input int nbusy, input logic [31:0] rdata);
        bit memop, mis;
        memop = v & (rd | wr);
        mis   = memop & m_misaligned(sz, addr);
        @(negedge clk);
        valid = v; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        alu_out = addr; store_data = sd; reg_write = rw; memToReg = mtr; rd_a = rda;
        dmem_ready = 1'($urandom % 2); dmem_rdata = $urandom;
        #1;
        check_eq("idle_req", dmem_req, 32'd0);
        check_eq("idle_mem_out", mem_out_o, 32'd0);
        check_eq("alu_pass", alu_out_o, addr);
        check_eq("rd_pass", rd_a_o, rda);
        if (!memop) begin
            check_eq("nm_stall", stall, 32'd0);
            check_eq("nm_rw", reg_write_o, v & rw);
            check_eq("nm_mtr", memToReg_o, mtr);
            check_eq("nm_mis", misalign_err, 32'd0);
        end else if (mis) begin
            check_eq("mis_err", misalign_err, 32'd1);
            check_eq("mis_stall", stall, 32'd0);
            check_eq("mis_rw", reg_write_o, 32'd0);
        end else begin
            check_eq("start_stall", stall, 32'd1);
            check_eq("start_rw", reg_write_o, 32'd0);
            check_eq("start_mis", misalign_err, 32'd0);
            for (int k = 1; k <= nbusy; k++) begin
                @(negedge clk);
                dmem_ready = (k == nbusy);
                dmem_rdata = (k == nbusy) ? rdata : $urandom;
                #1;
                check_eq("busy_req", dmem_req, 32'd1);
                check_eq("busy_we", dmem_we, wr);
                check_eq("busy_addr", dmem_addr, addr - (addr % 4));
                check_eq("busy_be", dmem_be, m_be(sz, addr));
                if (wr) check_eq("busy_wdata", dmem_wdata, m_wdata(sz, sd));
                check_eq("busy_stall", stall, 32'd1);
                check_eq("busy_rw", reg_write_o, 32'd0);
            end
            @(negedge clk);
            dmem_ready = 1'($urandom % 2); dmem_rdata = $urandom;
            #1;
            check_eq("done_stall", stall, 32'd0);
            check_eq("done_req", dmem_req, 32'd0);
            check_eq("done_rw", reg_write_o, rw & ~wr);
            check_eq("done_mem_out", mem_out_o, m_load(rdata, addr, sz, uns));
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = SZ_WORD;
        mem_unsigned = 1'b0; alu_out = 32'd0; store_data = 32'd0; reg_write = 1'b0;
        memToReg = 1'b0; rd_a = 5'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req", dmem_req, 32'd0);
        check_eq("rst_we", dmem_we, 32'd0);
        check_eq("rst_addr", dmem_addr, 32'd0);
        check_eq("rst_be", dmem_be, 32'd0);
        check_eq("rst_wdata", dmem_wdata, 32'd0);
        check_eq("rst_stall", stall, 32'd0);
        check_eq("rst_mis", misalign_err, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(1, 0, 0, SZ_WORD, 0, 32'h1234, 32'h0, 1, 0, 5'd5, 0, 32'h0);
        run_op(1, 1, 0, SZ_WORD, 0, 32'h100, 32'h0, 1, 1, 5'd6, 3, 32'hDEADBEEF);
        run_op(1, 1, 0, SZ_BYTE, 0, 32'h103, 32'h0, 1, 1, 5'd7, 1, 32'h80FF0000);
        run_op(1, 1, 0, SZ_BYTE, 1, 32'h103, 32'h0, 1, 1, 5'd7, 2, 32'h80FF0000);
        run_op(1, 1, 0, SZ_HALF, 1, 32'h102, 32'h0, 1, 1, 5'd8, 1, 32'h80FF0000);
        run_op(1, 1, 0, SZ_HALF, 0, 32'h102, 32'h0, 1, 1, 5'd8, 1, 32'h80FF0000);
        run_op(1, 0, 1, SZ_BYTE, 0, 32'h101, 32'hAB, 0, 0, 5'd0, 2, 32'h0);
        run_op(1, 0, 1, SZ_HALF, 0, 32'h202, 32'h1234CDEF, 0, 0, 5'd0, 1, 32'h0);
        run_op(1, 1, 0, SZ_WORD, 0, 32'h102, 32'h0, 1, 1, 5'd9, 1, 32'h0);
        run_op(1, 1, 0, SZ_HALF, 0, 32'h101, 32'h0, 1, 1, 5'd9, 1, 32'h0);
        run_op(0, 1, 0, SZ_WORD, 0, 32'h300, 32'h0, 1, 1, 5'd3, 1, 32'h0);

        // Reset in BUSY abandons the access; a later ready is ignored
        @(negedge clk);
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = SZ_WORD;
        alu_out = 32'h400; reg_write = 1'b1; dmem_ready = 1'b0;
        #1;
        check_eq("ab_start_stall", stall, 32'd1);
        @(negedge clk);
        #1;
        check_eq("ab_busy_req", dmem_req, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("ab_rst_stall", stall, 32'd0);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        #1;
        check_eq("ab_req_drop", dmem_req, 32'd0);
        check_eq("ab_idle_stall", stall, 32'd0);
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        check_eq("ab_ready_req", dmem_req, 32'd0);
        check_eq("ab_ready_stall", stall, 32'd0);
        check_eq("ab_ready_out", mem_out_o, 32'd0);
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        check_eq("ab_after_req", dmem_req, 32'd0);
        check_eq("ab_after_out", mem_out_o, 32'd0);
        check_eq("ab_after_rw", reg_write_o, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int kind;
            bit rd, wr, v;
            MemSize sz;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            v  = ($urandom_range(0, 7) != 0);
            rd = (kind == 1);
            wr = (kind == 2);
            sz = MemSize'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % (32'd1 << sz));
            run_op(v, rd, wr, sz, 1'($urandom % 2), a, $urandom, ~wr & 1'($urandom % 2),
                   1'($urandom % 2), 5'($urandom), int'($urandom_range(1, 4)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
